fetch_prefetch_queue: RTL

- Instruction prefetch stage between instruction memory and the cpu's instruction-read port.
- Fetches 16-bit words from a 1-cycle-latency memory port into a byte queue.
- Presents the cpu a 24-bit window (3 bytes) starting at the cpu's requested byte address, with a valid flag.
- Sequential address advance consumes bytes; any non-sequential address (jump, call, return, interrupt) flushes the queue and refetches.

---
 rtl/fetch_prefetch_queue.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_prefetch_queue.sv
// Instruction prefetch queue: fetches 16-bit words from a 1-cycle memory port
// into a byte queue and presents the cpu a 3-byte window at its byte address.
// Sequential advance consumes bytes; any other address flushes and refetches.
module fetch_prefetch_queue #(
  parameter int DEPTH_BYTES = 8,
  parameter int ADDR_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] iread_addr,
  output logic [23:0]       iread_data,
  output logic              iread_valid,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [15:0]       mem_data
);

  localparam int CW = $clog2(DEPTH_BYTES + 1);
  localparam int IW = $clog2(DEPTH_BYTES);
  typedef logic [CW-1:0] cnt_t;

  logic [DEPTH_BYTES-1:0][7:0] r_q;
  logic [ADDR_W-1:0]           r_head;
  logic [ADDR_W-1:0]           r_fetch;
  cnt_t                        r_count;
  logic                        r_inflight;
  logic                        r_inflight_skip;
  logic                        r_skip_next;     // next issued word is first of an odd-start stream
  logic                        r_epoch;
  logic                        r_inflight_epoch;
  logic                        r_started;       // low for the first cycle after reset release

  logic [ADDR_W-1:0]           w_off;
  logic                        w_seq;
  cnt_t                        w_offc;
  cnt_t                        w_cnt_ac;
  logic [CW:0]                 w_need;
  logic                        w_issue;
  logic                        w_append;
  logic [DEPTH_BYTES-1:0][7:0] w_sh;
  logic [DEPTH_BYTES-1:0][7:0] w_q_n;
  cnt_t                        w_cnt_n;

  assign w_off    = iread_addr - r_head;
  // The first cycle after reset is forced to behave as a redirect.
  assign w_seq    = r_started && (w_off <= ADDR_W'(r_count));
  assign w_offc   = w_off[CW-1:0];
  assign w_cnt_ac = r_count - w_offc;
  // Room check counts the word returning this cycle plus the one about to issue.
  assign w_need   = {1'b0, w_cnt_ac} + (r_inflight ? (CW+1)'(2) : '0) + (CW+1)'(2);
  assign w_issue  = reset && w_seq && (w_need <= (CW+1)'(DEPTH_BYTES));
  // A word returning during a redirect cycle belongs to the old stream.
  assign w_append = r_inflight && (r_inflight_epoch == r_epoch) && w_seq;

  assign mem_req  = w_issue;
  assign mem_addr = {r_fetch[ADDR_W-1:1], 1'b0};

  // Queue contents after discarding bytes below iread_addr; bytes past count read 0.
  always_comb begin
    cnt_t idx;
    w_sh = '0;
    for (int k = 0; k < DEPTH_BYTES; k++) begin
      idx = cnt_t'(k) + w_offc;
      if (cnt_t'(k) < w_cnt_ac && idx < cnt_t'(DEPTH_BYTES))
        w_sh[k] = r_q[idx[IW-1:0]];
    end
  end

  // Cpu window and valid flag.
  always_comb begin
    iread_valid = w_seq && (w_cnt_ac >= cnt_t'(3));
    iread_data  = w_seq ? {w_sh[2], w_sh[1], w_sh[0]} : 24'h0;
  end

  // Append the returning word behind the post-consume contents.
  always_comb begin
    cnt_t ai;
    cnt_t ai1;
    w_q_n = w_sh;
    ai    = w_cnt_ac;
    ai1   = w_cnt_ac + cnt_t'(1);
    if (w_append) begin
      if (r_inflight_skip) begin
        if (ai < cnt_t'(DEPTH_BYTES)) w_q_n[ai[IW-1:0]] = mem_data[15:8];
      end else begin
        if (ai  < cnt_t'(DEPTH_BYTES)) w_q_n[ai[IW-1:0]]  = mem_data[7:0];
        if (ai1 < cnt_t'(DEPTH_BYTES)) w_q_n[ai1[IW-1:0]] = mem_data[15:8];
      end
    end
    w_cnt_n = w_cnt_ac + (w_append ? (r_inflight_skip ? cnt_t'(1) : cnt_t'(2)) : cnt_t'(0));
  end

  // Queue, address and fetch-tracking state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q              <= '0;
      r_head           <= '0;
      r_fetch          <= '0;
      r_count          <= '0;
      r_inflight       <= 1'b0;
      r_inflight_skip  <= 1'b0;
      r_skip_next      <= 1'b0;
      r_epoch          <= 1'b0;
      r_inflight_epoch <= 1'b0;
      r_started        <= 1'b0;
    end else begin
      r_started  <= 1'b1;
      r_inflight <= w_issue;
      r_head     <= iread_addr;
      if (!w_seq) begin
        r_q         <= '0;
        r_count     <= '0;
        r_fetch     <= {iread_addr[ADDR_W-1:1], 1'b0};
        r_epoch     <= ~r_epoch;
        r_skip_next <= iread_addr[0];
      end else begin
        r_q     <= w_q_n;
        r_count <= w_cnt_n;
      end
      if (w_issue) begin
        r_fetch          <= r_fetch + ADDR_W'(2);
        r_inflight_epoch <= r_epoch;
        r_inflight_skip  <= r_skip_next;
        r_skip_next      <= 1'b0;
      end
    end
  end

endmodule
